// File: rtl/nand_status_check.sv
// NAND read-status evaluator: polls SR[6], confirms SR[0], reports pass/fail.
// Optional STATUS_LOG_EN adds saturating write/erase fail counters.
module nand_status_check #(
  parameter int         POLL_MAX  = 256,
  parameter int         CONFIRM   = 2,
  parameter logic [4:0] ST_RDSR   = 5'd16,
  parameter logic [4:0] ST_BADBLK = 5'd17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] state,
  input  logic       en_write_page,
  input  logic       en_erase_page,
  input  logic       re1,
  input  logic [7:0] io_in,
  output logic       write_complete,
  output logic       write_fail,
  output logic [1:0] erase_success,
  output logic [7:0] status_byte,
  output logic       status_timeout
`ifdef STATUS_LOG_EN
  ,
  output logic [15:0] wr_fail_cnt,
  output logic [15:0] er_fail_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, POLL, DONE} fsm_t;

  fsm_t       fsm;
  logic       re1_d;
  logic [8:0] poll_cnt;
  logic [1:0] ok_cnt;
  logic       last_fail;
  logic       verdict;
  logic       timeout_r;
  logic       op_wr;

  logic       sample;
  logic       active;
  logic       clear;
  logic [8:0] poll_nx;
  logic [1:0] ok_nx;
  logic       confirm;
  logic       to_hit;

  assign sample = re1 & ~re1_d;
  assign active = (state == ST_RDSR) &
                  (en_write_page ^ en_erase_page);
  assign clear  = !((state == ST_RDSR) || (state == ST_BADBLK)) ||
                  !(en_write_page || en_erase_page);
  assign poll_nx = (poll_cnt == 9'h1ff) ? poll_cnt : poll_cnt + 9'd1;
  assign to_hit  = int'(poll_nx) >= POLL_MAX;
  assign confirm = ok_nx == 2'(CONFIRM);

  // A ready byte whose SR[0] disagrees restarts the run at one.
  always_comb begin
    ok_nx = 2'd0;
    if (io_in[6]) begin
      if (ok_cnt == 2'd0 || io_in[0] == last_fail)
        ok_nx = ok_cnt + 2'd1;
      else
        ok_nx = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm            <= IDLE;
      re1_d          <= 1'b1;
      poll_cnt       <= '0;
      ok_cnt         <= '0;
      last_fail      <= 1'b0;
      verdict        <= 1'b0;
      timeout_r      <= 1'b0;
      op_wr          <= 1'b0;
      write_complete <= 1'b0;
      write_fail     <= 1'b0;
      erase_success  <= 2'd0;
      status_byte    <= 8'd0;
      status_timeout <= 1'b0;
    end else begin
      re1_d <= re1;
      unique case (fsm)
        IDLE: begin
          if (active) begin
            poll_cnt  <= '0;
            ok_cnt    <= '0;
            last_fail <= 1'b0;
            op_wr     <= en_write_page;
            fsm       <= POLL;
          end
        end
        POLL: begin
          if (!active) begin
            fsm <= IDLE;
          end else if (sample) begin
            status_byte <= io_in;
            poll_cnt    <= poll_nx;
            ok_cnt      <= ok_nx;
            if (io_in[6]) last_fail <= io_in[0];
            if (confirm) begin
              fsm       <= DONE;
              verdict   <= io_in[0];
              timeout_r <= 1'b0;
            end else if (to_hit) begin
              fsm       <= DONE;
              verdict   <= 1'b1;
              timeout_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (clear) begin
            fsm            <= IDLE;
            write_complete <= 1'b0;
            write_fail     <= 1'b0;
            erase_success  <= 2'd0;
            status_timeout <= 1'b0;
          end else begin
            if (op_wr) begin
              write_complete <= 1'b1;
              write_fail     <= verdict;
            end else begin
              erase_success  <= verdict ? 2'd2 : 2'd1;
            end
            status_timeout <= timeout_r;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef STATUS_LOG_EN
  logic fail_entry;

  assign fail_entry = (fsm == POLL) && active && sample &&
                      ((confirm && io_in[0]) || (!confirm && to_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_fail_cnt <= '0;
      er_fail_cnt <= '0;
    end else if (fail_entry) begin
      if (op_wr) begin
        if (wr_fail_cnt != 16'hffff) wr_fail_cnt <= wr_fail_cnt + 16'd1;
      end else begin
        if (er_fail_cnt != 16'hffff) er_fail_cnt <= er_fail_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
